// File: rtl/dds_da4_ctrl_if.sv
// Signal bundle between the DDS/DAC controller and its environment.
// The slave side is the controller; the master side drives enable, tuning and ROM data.
interface dds_da4_ctrl_if;
  logic        enable;
  logic [31:0] freq_word;
  logic        freq_load;
  logic [9:0]  rom_addr;
  logic [11:0] rom_dout;
  logic        sync_n;
  logic        sclk;
  logic        din;
  logic        busy;
  logic        sample_done;

  modport slave (
    input  enable, freq_word, freq_load, rom_dout,
    output rom_addr, sync_n, sclk, din, busy, sample_done
  );

  modport master (
    output enable, freq_word, freq_load, rom_dout,
    input  rom_addr, sync_n, sclk, din, busy, sample_done
  );
endinterface

// File: rtl/dds_da4_ctrl.sv
// DDS phase accumulator that streams each ROM sample to a quad serial DAC as a 32-bit frame.
// Define DDS_INTREF_EN to send a one-time internal-reference-on command after reset.
module dds_da4_ctrl #(
  parameter int unsigned CLK_DIV = 2,
  parameter logic [3:0]  DAC_CH  = 4'b1111
) (
  input logic           clk,
  input logic           rst_n,
  dds_da4_ctrl_if.slave bus
);
  localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);

`ifdef DDS_INTREF_EN
  typedef enum logic [2:0] {StIdle, StFetch, StLatch, StShift, StGap, StInit} state_e;
  localparam state_e StReset = StInit;
`else
  typedef enum logic [2:0] {StIdle, StFetch, StLatch, StShift, StGap} state_e;
  localparam state_e StReset = StIdle;
`endif

  state_e      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [5:0]  half_q, half_d;
  logic [31:0] frame_q, frame_d;
  logic [31:0] phase_q, phase_d;
  logic [31:0] inc_q, inc_d;
  logic        init_q;
  logic        div_last;

`ifdef DDS_INTREF_EN
  logic init_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) init_q <= 1'b0;
    else        init_q <= init_d;
  end
`else
  assign init_q = 1'b0;
`endif

  assign div_last = (div_q == DivLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StReset;
      div_q   <= '0;
      half_q  <= '0;
      frame_q <= '0;
      phase_q <= '0;
      inc_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      half_q  <= half_d;
      frame_q <= frame_d;
      phase_q <= phase_d;
      inc_q   <= inc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    half_d  = half_q;
    frame_d = frame_q;
    phase_d = phase_q;
    inc_d   = bus.freq_load ? bus.freq_word : inc_q;
`ifdef DDS_INTREF_EN
    init_d  = init_q;
`endif
    case (state_q)
      StIdle: begin
        if (bus.enable) state_d = StFetch;
      end
      StFetch: state_d = StLatch;
      StLatch: begin
        frame_d = {4'b0000, 4'b0011, DAC_CH, bus.rom_dout, 8'h00};
        phase_d = phase_q + inc_q;
        div_d   = '0;
        half_d  = '0;
        state_d = StShift;
      end
      StShift: begin
        // 64 half-periods of sclk; the next bit is presented as sclk rises again.
        if (div_last) begin
          div_d  = '0;
          half_d = half_q + 6'd1;
          if (half_q[0]) frame_d = {frame_q[30:0], 1'b0};
          if (half_q == 6'd63) state_d = StGap;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      StGap: begin
        if (div_last) begin
          div_d  = '0;
          half_d = half_q + 6'd1;
          if (half_q[0]) begin
            half_d  = '0;
            state_d = (bus.enable && !init_q) ? StFetch : StIdle;
`ifdef DDS_INTREF_EN
            init_d  = 1'b0;
`endif
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
`ifdef DDS_INTREF_EN
      StInit: begin
        frame_d = 32'h0800_0001;
        div_d   = '0;
        half_d  = '0;
        init_d  = 1'b1;
        state_d = StShift;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  assign bus.rom_addr    = phase_q[31:22];
  assign bus.sync_n      = (state_q != StShift);
  assign bus.sclk        = (state_q == StShift) ? ~half_q[0] : 1'b1;
  assign bus.din         = (state_q == StShift) && frame_q[31];
  // Gated by rst_n so busy is low during reset even when the reset state is INIT.
  assign bus.busy        = rst_n && (state_q != StIdle);
  assign bus.sample_done = (state_q == StGap) && div_last && half_q[0] && !init_q;
endmodule
